// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle adder-subtractor: FSM states and the NZCV flag bundle.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/add_sub_slice.sv
// Purely combinational N-bit ripple adder; also exposes the carry into bit N-1 for overflow.
module add_sub_slice #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  always_comb begin : p_ripple
    logic c;
    sum      = '0;
    c        = cin;
    c_msb_in = cin;
    for (int i = 0; i < int'(N); i++) begin
      if (i == int'(N) - 1) c_msb_in = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/add_sub_multicycle.sv
// Multi-cycle adder-subtractor: SLICE bits per clock through one shared slice adder,
// carry registered between slices, valid/ready on both sides, NZCV flags on completion.
module add_sub_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("add_sub_multicycle: SLICE must divide WIDTH exactly");
  end

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_result_nxt;
  logic             r_carry;
  logic [CW-1:0]    r_idx;
  flags_t           r_flags;
  logic [SLICE-1:0] w_sum;
  logic             w_cout, w_cmsb, w_accept, w_last;
  logic [31:0]      w_base;

  assign w_base   = 32'(r_idx) * SLICE;
  assign w_last   = (r_idx == LastIdx);
  assign w_accept = in_valid && (r_state == IDLE);

  add_sub_slice #(
    .N(SLICE)
  ) u_slice (
    .a       (r_a[w_base +: SLICE]),
    .b       (r_b[w_base +: SLICE]),
    .cin     (r_carry),
    .sum     (w_sum),
    .cout    (w_cout),
    .c_msb_in(w_cmsb)
  );

  // Zero must see the complete result, so merge the current slice in before registering.
  always_comb begin
    w_result_nxt                   = r_result;
    w_result_nxt[w_base +: SLICE] = w_sum;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= subtract ? ~B : B;
      r_carry <= subtract;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_result <= w_result_nxt;
      r_carry  <= w_cout;
      r_idx    <= r_idx + CW'(1);
      if (w_last) begin
        r_flags.negative <= w_result_nxt[WIDTH-1];
        r_flags.zero     <= (w_result_nxt == '0);
        r_flags.carry    <= w_cout;
        r_flags.overflow <= w_cmsb ^ w_cout;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_flags.carry;
  assign overflow  = r_flags.overflow;
  assign zero      = r_flags.zero;
  assign negative  = r_flags.negative;

endmodule

// File: tb/tb_add_sub_multicycle.sv
// Directed bench: vector table on the default 64/16 instance, handshake and reset sequences,
// plus 8/4 and 8/8 instances for the parametrised latency cases.
module tb_add_sub_multicycle;

  localparam int Limit = 20;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, subtract;
  logic [63:0] a_in, b_in;
  logic        in_ready, out_valid, c_out, v_out, z_out, n_out;
  logic [63:0] res_out;

  logic        s4_ivalid, s4_ordy, s4_sub, s4_irdy, s4_ovalid, s4_c, s4_v, s4_z, s4_n;
  logic [7:0]  s4_a, s4_b, s4_res;
  logic        s8_ivalid, s8_ordy, s8_sub, s8_irdy, s8_ovalid, s8_c, s8_v, s8_z, s8_n;
  logic [7:0]  s8_a, s8_b, s8_res;

  int errors = 0;
  int checks = 0;

  add_sub_multicycle u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .subtract(subtract), .out_valid(out_valid), .out_ready(out_ready),
    .result(res_out), .carry_out(c_out), .overflow(v_out), .zero(z_out), .negative(n_out)
  );

  add_sub_multicycle #(.WIDTH(8), .SLICE(4)) u_dut_s4 (
    .clk(clk), .reset_n(reset_n), .in_valid(s4_ivalid), .in_ready(s4_irdy),
    .A(s4_a), .B(s4_b), .subtract(s4_sub), .out_valid(s4_ovalid), .out_ready(s4_ordy),
    .result(s4_res), .carry_out(s4_c), .overflow(s4_v), .zero(s4_z), .negative(s4_n)
  );

  add_sub_multicycle #(.WIDTH(8), .SLICE(8)) u_dut_s8 (
    .clk(clk), .reset_n(reset_n), .in_valid(s8_ivalid), .in_ready(s8_irdy),
    .A(s8_a), .B(s8_b), .subtract(s8_sub), .out_valid(s8_ovalid), .out_ready(s8_ordy),
    .result(s8_res), .carry_out(s8_c), .overflow(s8_v), .zero(s8_z), .negative(s8_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    a_in = v.a; b_in = v.b; subtract = v.sub; in_valid = 1'b1;
    chk({v.name, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in = ~v.a; b_in = ~v.b; subtract = ~v.sub;  // must be ignored while running
    lat = 0;
    while (!out_valid && lat < Limit) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, " latency"}, 64'(lat), 64'd4);
    chk({v.name, " result"}, res_out, v.res);
    chk({v.name, " NZCV"}, 64'({n_out, z_out, c_out, v_out}), 64'({v.n, v.z, v.c, v.v}));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, " back to idle"}, 64'(in_ready), 64'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int seen;
    vecs[0] = '{"add 0+1", 64'h0, 64'h1, 1'b0, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"add halves", 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"slice carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
                64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"max pos+1", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"min+min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                64'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{"1-1", 64'h1, 64'h1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{"0-1", 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{"min-1", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; subtract = 1'b0; a_in = '0; b_in = '0;
    s4_ivalid = 1'b0; s4_ordy = 1'b0; s4_sub = 1'b0; s4_a = '0; s4_b = '0;
    s8_ivalid = 1'b0; s8_ordy = 1'b0; s8_sub = 1'b0; s8_a = '0; s8_b = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", res_out, 64'd0);
    chk("reset NZCV", 64'({n_out, z_out, c_out, v_out}), 64'd0);

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Stall in DONE, then in_valid held high across the release.
    a_in = 64'd5; b_in = 64'd3; subtract = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a_in = 64'd99;
    lat = 0;
    while (!out_valid && lat < Limit) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs latency", 64'(lat), 64'd4);
    chk("hs result", res_out, 64'd8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hs stall result", res_out, 64'd8);
      chk("hs stall NZCV", 64'({n_out, z_out, c_out, v_out}), 64'd0);
      chk("hs stall valid/ready", 64'({out_valid, in_ready}), 64'b10);
    end
    a_in = 64'd10; b_in = 64'd20; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs idle cycle valid/ready", 64'({out_valid, in_ready}), 64'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hs second accepted", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < Limit) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs2 latency", 64'(lat), 64'd4);
    chk("hs2 result", res_out, 64'd30);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the second RUN cycle aborts with no output.
    a_in = 64'h1111_1111_1111_1111; b_in = 64'h1111_1111_1111_1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort result", res_out, 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort no output", 64'(seen), 64'd0);

    // WIDTH=8 SLICE=4
    s4_a = 8'h7F; s4_b = 8'h01; s4_sub = 1'b0; s4_ivalid = 1'b1;
    @(posedge clk); #1;
    s4_ivalid = 1'b0;
    lat = 0;
    while (!s4_ovalid && lat < Limit) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("s4 latency", 64'(lat), 64'd2);
    chk("s4 result", 64'(s4_res), 64'h80);
    chk("s4 NZCV", 64'({s4_n, s4_z, s4_c, s4_v}), 64'b1001);
    s4_ordy = 1'b1;
    @(posedge clk); #1;
    s4_ordy = 1'b0;
    s4_a = 8'h00; s4_b = 8'h01; s4_sub = 1'b1; s4_ivalid = 1'b1;
    @(posedge clk); #1;
    s4_ivalid = 1'b0;
    lat = 0;
    while (!s4_ovalid && lat < Limit) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("s4 sub result", 64'(s4_res), 64'hFF);
    chk("s4 sub NZCV", 64'({s4_n, s4_z, s4_c, s4_v}), 64'b1000);
    s4_ordy = 1'b1;
    @(posedge clk); #1;
    s4_ordy = 1'b0;

    // WIDTH=8 SLICE=8
    s8_a = 8'h7F; s8_b = 8'h01; s8_sub = 1'b0; s8_ivalid = 1'b1;
    @(posedge clk); #1;
    s8_ivalid = 1'b0;
    lat = 0;
    while (!s8_ovalid && lat < Limit) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("s8 latency", 64'(lat), 64'd1);
    chk("s8 result", 64'(s8_res), 64'h80);
    chk("s8 NZCV", 64'({s8_n, s8_z, s8_c, s8_v}), 64'b1001);
    s8_ordy = 1'b1;
    @(posedge clk); #1;
    s8_ordy = 1'b0;
    chk("s8 idle", 64'(s8_irdy), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_sub_multicycle.md
Name: add_sub_multicycle

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor. Successor to the single-cycle 64-bit ripple add/subtract block.
- Processes WIDTH-bit operands SLICE bits per clock through one shared slice adder. The carry is registered between slices.
- Uses valid/ready handshakes on both input and output.
- Produces result plus ARM-style NZCV flags, for use by the ALU/flags path of the datapath.

Parameters:
- WIDTH, 64: operand/result width in bits.
- SLICE, 16: bits added per cycle. Must divide WIDTH exactly; elaboration error otherwise.
- NSLICE (localparam), WIDTH/SLICE: cycles of computation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and subtract are valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- subtract  input  1  0: A+B; 1: A-B (A + ~B + 1).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB. On subtract, 1 means no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE; result, carry_out, overflow, zero, negative, out_valid all 0.
  - in_ready reads 1 in the cycle after reset.
  - Reset mid-operation aborts the operation with no output produced.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid&&in_ready:
    - latch A;
    - latch B, or ~B when subtract=1;
    - set carry register = subtract and slice index = 0;
    - go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: the slice adder sums slice k of A and B_eff with the carry register. Write the sum bits into result slice k, register the slice carry, k++.
  - On the last slice (k==NSLICE-1):
    - capture carry-into-MSB from the slice adder;
    - compute the flags;
    - go to DONE.
  - Port A/B/subtract changes during RUN are ignored.
- DONE:
  - out_valid=1; result and flags held stable.
  - On an edge with out_ready=1, go to IDLE.
  - out_ready low: hold indefinitely, in_ready=0.
- Latency:
  - Accept at edge 0; out_valid high after edge NSLICE (4 cycles at default).
  - Minimum period between accepts is NSLICE+2 cycles. No bypass from DONE straight to a new accept.
- Flags:
  - zero is computed from the complete result, not per slice.
  - Flags are meaningful only while out_valid=1.
- Boundary cases:
  - SLICE==WIDTH gives NSLICE=1: one RUN cycle, same rules.
  - Carry propagates across slice boundaries only via the carry register. It is never combinational between cycles.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum state_t {IDLE, RUN, DONE};
  - typedef struct flags_t {negative, zero, carry, overflow}.
- Sub-module add_sub_slice, parameter N:
  - purely combinational N-bit ripple adder;
  - inputs a, b, cin;
  - outputs sum, cout, and c_msb_in (carry into bit N-1, used for overflow).
- The top level holds the FSM, slice counter, operand registers, carry register and result register.

Test Plan:
- Default params, A=0, B=1, add: out_valid exactly 4 cycles after accept. Result=1, C=0, V=0, Z=0, N=0.
- A=0xFFFF_FFFF_0000_0000, B=0x0000_0000_FFFF_FFFF, add: result=0xFFFF_FFFF_FFFF_FFFF, N=1, C=0, V=0.
- Carry across slices:
  - 0x0000_0000_0000_FFFF+1 gives 0x0000_0000_0001_0000, C=0.
  - 0x7FFF_FFFF_FFFF_FFFF+1 gives 0x8000_0000_0000_0000, V=1, N=1.
- Sign/borrow edge cases:
  - 0x8000_0000_0000_0000 + 0x8000_0000_0000_0000 gives 0, C=1, V=1, Z=1.
  - 1-1 gives 0, C=1, Z=1.
  - 0-1 gives 0xFFFF_FFFF_FFFF_FFFF, C=0, N=1.
- Handshake:
  - Hold out_ready=0 for 3 cycles in DONE: result and flags are stable, in_ready=0.
  - Raise out_ready: IDLE next cycle, in_ready=1.
  - in_valid held high throughout: the second operation is accepted only after that IDLE cycle.
- Reset and parametrisation:
  - Assert reset_n=0 in RUN cycle 2: after the edge, state is IDLE, out_valid=0, result=0, in_ready=1.
  - WIDTH=8, SLICE=4: 0x7F+0x01 gives 0x80, V=1, latency 2.
  - WIDTH=8, SLICE=8: latency 1.
